// File: rtl/alu_op_sequencer.sv
// Sequences one ALU operation at a time: drives the one-hot control word and operands for a
// per-opcode settle time, then captures the ALU result into a valid/ready response port.
module alu_op_sequencer #(
  parameter int unsigned WAIT_NARROW = 1,
  parameter int unsigned WAIT_MUL    = 2,
  parameter int unsigned WAIT_DIV    = 4
) (
  input  logic        clock_i,
  input  logic        clear_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_a_i,
  input  logic [31:0] req_b_i,
  output logic [11:0] alu_control_o,
  output logic [31:0] alu_a_o,
  output logic [31:0] alu_b_o,
  input  logic [31:0] alu_zlow_i,
  input  logic [31:0] alu_zhigh_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_lo_o,
  output logic [31:0] rsp_hi_o,
  output logic        rsp_err_o
);

  localparam int unsigned MaxWait0 = (WAIT_NARROW > WAIT_MUL) ? WAIT_NARROW : WAIT_MUL;
  localparam int unsigned MaxWait  = (MaxWait0 > WAIT_DIV) ? MaxWait0 : WAIT_DIV;
  localparam int unsigned CntW     = (MaxWait > 1) ? $clog2(MaxWait) : 1;

  localparam logic [CntW-1:0] NarrowCnt = CntW'(WAIT_NARROW - 1);
  localparam logic [CntW-1:0] MulCnt    = CntW'(WAIT_MUL - 1);
  localparam logic [CntW-1:0] DivCnt    = CntW'(WAIT_DIV - 1);

  localparam logic [3:0] OpMul  = 4'd2;
  localparam logic [3:0] OpDiv  = 4'd3;
  localparam logic [3:0] OpLast = 4'd11;

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [11:0]     ctrl_q, ctrl_d;
  logic [31:0]     a_q, a_d;
  logic [31:0]     b_q, b_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     rsp_lo_q, rsp_lo_d;
  logic [31:0]     rsp_hi_q, rsp_hi_d;
  logic            rsp_err_q, rsp_err_d;

  logic [CntW-1:0] load_cnt;
  logic            req_bad;
  logic            op_wide;

  always_comb begin
    load_cnt = NarrowCnt;
    case (req_op_i)
      OpMul:   load_cnt = MulCnt;
      OpDiv:   load_cnt = DivCnt;
      default: load_cnt = NarrowCnt;
    endcase
  end

  // Illegal opcodes and divide-by-zero never reach the ALU.
  assign req_bad = (req_op_i > OpLast) || ((req_op_i == OpDiv) && (req_b_i == '0));
  assign op_wide = (op_q == OpMul) || (op_q == OpDiv);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ctrl_d    = ctrl_q;
    a_d       = a_q;
    b_d       = b_q;
    op_d      = op_q;
    rsp_lo_d  = rsp_lo_q;
    rsp_hi_d  = rsp_hi_q;
    rsp_err_d = rsp_err_q;
    case (state_q)
      StIdle: begin
        if (req_valid_i) begin
          a_d   = req_a_i;
          b_d   = req_b_i;
          op_d  = req_op_i;
          cnt_d = load_cnt;
          if (req_bad) begin
            state_d   = StResp;
            rsp_lo_d  = '0;
            rsp_hi_d  = '0;
            rsp_err_d = 1'b1;
          end else begin
            state_d = StExec;
            ctrl_d  = 12'b1 << req_op_i;
          end
        end
      end
      StExec: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          rsp_lo_d  = alu_zlow_i;
          rsp_hi_d  = op_wide ? alu_zhigh_i : '0;
          rsp_err_d = 1'b0;
          ctrl_d    = '0;
          state_d   = StResp;
        end
      end
      StResp: begin
        if (rsp_ready_i) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        ctrl_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge clear_ni) begin
    if (!clear_ni) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      ctrl_q    <= '0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      rsp_lo_q  <= '0;
      rsp_hi_q  <= '0;
      rsp_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ctrl_q    <= ctrl_d;
      a_q       <= a_d;
      b_q       <= b_d;
      op_q      <= op_d;
      rsp_lo_q  <= rsp_lo_d;
      rsp_hi_q  <= rsp_hi_d;
      rsp_err_q <= rsp_err_d;
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign rsp_valid_o   = (state_q == StResp);
  assign alu_control_o = ctrl_q;
  assign alu_a_o       = a_q;
  assign alu_b_o       = b_q;
  assign rsp_lo_o      = rsp_lo_q;
  assign rsp_hi_o      = rsp_hi_q;
  assign rsp_err_o     = rsp_err_q;

  a_ctrl_onehot: assert property (@(posedge clock_i) disable iff (!clear_ni)
    $onehot0(ctrl_q));

  a_ctrl_only_exec: assert property (@(posedge clock_i) disable iff (!clear_ni)
    (state_q != StExec) |-> (ctrl_q == '0));

  a_rsp_stable: assert property (@(posedge clock_i) disable iff (!clear_ni)
    (state_q == StResp && !rsp_ready_i) |=>
      (state_q == StResp && $stable(rsp_lo_q) && $stable(rsp_hi_q) && $stable(rsp_err_q)));

endmodule
